square_extractor_iter: RTL and testbench
========================================

// Module: square_extractor_iter
// PURPOSE
// - Sequential integer square root: dout = floor(sqrt(radicand)), remainder = radicand - dout^2.
// - Free-running, no handshake. Samples radicand, iterates one root bit per cycle (MSB first),
//   then publishes the result and re-samples.
// - Arithmetic helper for datapaths that tolerate a bounded multi-cycle latency.
// PARAMETERS
// - WIDTH  default 4  root width in bits; radicand and remainder are 2*WIDTH bits (WIDTH >= 1)
// PORTS
// - clk        input   1          rising-edge clock, the only clock
// - rst        input   1          asynchronous reset, active-high
// - radicand   input   2*WIDTH    unsigned operand
// - dout       output  WIDTH      unsigned integer square root
// - remainder  output  2*WIDTH    radicand - dout*dout, zero-extended
// BEHAVIOUR
// - Reset (rst=1, async): dout=0, remainder=0, state=LOAD, step counter=0, internal regs=0.
// - Two-state FSM, fixed period of WIDTH+1 cycles:
//   - LOAD (1 cycle): capture radicand into x_reg; clear root_reg and rem_reg (WIDTH+2 bits);
//     counter=WIDTH-1; go to CALC.
//   - CALC (WIDTH cycles), step i = counter, MSB first:
//     - r    = (rem_reg<<2) | x_reg[2i+1:2i]
//     - t    = (root_reg<<2) | 1
//     - r>=t : rem_reg = r - t, root_reg = (root_reg<<1)|1
//     - else : rem_reg = r,     root_reg = root_reg<<1
//     - counter==0 : dout <= final root, remainder <= zero-extended final rem; go to LOAD.
//       Else decrement counter.
// - Outputs change only on the last CALC edge; held stable for the rest of the period.
// - Latency: radicand present at a LOAD edge -> result visible W+1 edges later.
//   Worst case from an arbitrary radicand change: 2*(W+1) cycles, always <= 4*WIDTH for WIDTH >= 1.
//   Radicand must be held for that long.
// - Radicand changes during CALC are ignored (x_reg is used); picked up at the next LOAD.
// - Invariants on every published result:
//   - dout*dout + remainder == sampled radicand
//   - remainder <= 2*dout
// - Full-scale input 2^(2W)-1 -> dout = 2^W-1, remainder = 2^(W+1)-2. No overflow anywhere.
// - Reset mid-operation aborts the computation; outputs go to 0; restart at LOAD after release.
// CONFIGURATION
// - SQUARE_EXTRACTOR_DONE_EN defined:
//   - Adds output port done (1 bit, reset 0).
//   - done=1 for exactly the one cycle after dout/remainder update (registered with them);
//     0 otherwise.
// - SQUARE_EXTRACTOR_DONE_EN undefined: no done port; behaviour otherwise identical.
// TESTING (WIDTH=4, radicand driven on negedge, checked 16 cycles later)
// - rst pulse, radicand=0 -> dout=0, remainder=0; outputs 0 during reset.
// - radicand=255 -> dout=15, remainder=30.
// - radicand=16 -> dout=4, remainder=0; radicand=15 -> dout=3, remainder=6.
// - radicand=200 -> dout=14, remainder=4; radicand=1 -> dout=1, remainder=0.
// - Assert rst mid-CALC with radicand=100 -> dout=0, remainder=0 immediately;
//   after release -> dout=10, remainder=0 within 10 cycles.
// - Random radicand, 1000 iterations -> dout*dout+remainder==radicand and remainder<=2*dout;
//   with SQUARE_EXTRACTOR_DONE_EN, done pulses every 5 cycles.

Source files
------------

// File: rtl/square_extractor_iter_if.sv
// Operand/result bundle for the iterative square-root extractor.
// The driver (master) supplies the radicand; the extractor (slave) returns
// the root, the remainder and, when SQUARE_EXTRACTOR_DONE_EN is defined,
// a one-cycle done strobe.
interface square_extractor_iter_if #(
  parameter int WIDTH = 4
);
  logic [2*WIDTH-1:0] radicand;
  logic [WIDTH-1:0]   dout;
  logic [2*WIDTH-1:0] remainder;
`ifdef SQUARE_EXTRACTOR_DONE_EN
  logic               done;

  modport master (output radicand, input dout, input remainder, input done);
  modport slave  (input radicand, output dout, output remainder, output done);
`else
  modport master (output radicand, input dout, input remainder);
  modport slave  (input radicand, output dout, output remainder);
`endif
endinterface

// File: rtl/square_extractor_iter.sv
// Free-running sequential integer square root.
// Every WIDTH+1 cycles the radicand is sampled (LOAD) and one root bit is
// resolved per cycle, MSB first (CALC). dout/remainder update together on
// the last CALC edge and are held for the rest of the period.
// Optional feature macro: SQUARE_EXTRACTOR_DONE_EN adds a done strobe that
// is high for exactly the cycle following each result update.
module square_extractor_iter #(
  parameter int WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  square_extractor_iter_if.slave  bus
);

  // Partial remainder needs two guard bits beyond the root width.
  localparam int RW = WIDTH + 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    LOAD = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [2*WIDTH-1:0] x_reg;
  logic [WIDTH-1:0]   root_reg;
  logic [RW-1:0]      rem_reg;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] x_shift;
  logic [1:0]         pair;
  logic [RW-1:0]      r_val;
  logic [RW-1:0]      t_val;
  logic               ge;
  logic [RW-1:0]      rem_next;
  logic [WIDTH-1:0]   root_next;
  logic               last_step;

  logic [WIDTH-1:0]   dout_reg;
  logic [2*WIDTH-1:0] rem_out_reg;

  // State register: LOAD/CALC sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the single restoring-square-root step.
  always_comb begin
    state_next = state;
    x_shift    = x_reg >> {cnt, 1'b0};
    pair       = x_shift[1:0];
    r_val      = {rem_reg[RW-3:0], pair};
    t_val      = {root_reg, 2'b01};
    ge         = (r_val >= t_val);
    rem_next   = ge ? (r_val - t_val) : r_val;
    root_next  = (root_reg << 1) | WIDTH'(ge);
    last_step  = (state == CALC) && (cnt == '0);
    case (state)
      LOAD:    state_next = CALC;
      CALC:    if (cnt == '0) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Datapath: sample the operand, iterate, and publish on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg       <= '0;
      root_reg    <= '0;
      rem_reg     <= '0;
      cnt         <= '0;
      dout_reg    <= '0;
      rem_out_reg <= '0;
    end else begin
      case (state)
        LOAD: begin
          x_reg    <= bus.radicand;
          root_reg <= '0;
          rem_reg  <= '0;
          cnt      <= CW'(WIDTH - 1);
        end
        CALC: begin
          root_reg <= root_next;
          rem_reg  <= rem_next;
          if (cnt == '0) begin
            dout_reg    <= root_next;
            rem_out_reg <= (2*WIDTH)'(rem_next);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout      = dout_reg;
  assign bus.remainder = rem_out_reg;

`ifdef SQUARE_EXTRACTOR_DONE_EN
  logic done_reg;

  // Strobe registered alongside the result so it marks the fresh value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= last_step;
    end
  end

  assign bus.done = done_reg;
`else
  logic unused_last_step;
  assign unused_last_step = last_step;
`endif

endmodule

// File: tb/tb_square_extractor_iter.sv
// Self-checking bench for square_extractor_iter at WIDTH=4.
// Radicands are driven on the falling edge and held long enough for the
// worst-case latency; expected results are queued when driven and popped
// when the output is sampled.
module tb_square_extractor_iter;

  localparam int W    = 4;
  localparam int HOLD = 16;

  typedef struct {
    int rad;
    int exp_dout;
    int exp_rem;
  } vec_t;

  typedef struct {
    string name;
    int    rad;
    int    exp_dout;
    int    exp_rem;
  } sb_t;

  logic clk;
  logic rst;

  square_extractor_iter_if #(.WIDTH(W)) bus ();

  square_extractor_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  total;
  int  bad;
  sb_t exp_q[$];
  vec_t vecs[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: smallest-step search for floor(sqrt(v)).
  function automatic int isqrt(input int v);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string name, input int rad, input int ed, input int er);
    sb_t e;
    @(negedge clk);
    bus.radicand = (2*W)'(rad);
    e.name = name;
    e.rad = rad;
    e.exp_dout = ed;
    e.exp_rem = er;
    exp_q.push_back(e);
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic popAndCheck();
    sb_t e;
    int d;
    int r;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    d = int'(bus.dout);
    r = int'(bus.remainder);
    checkOutput({e.name, "_dout"}, d, e.exp_dout);
    checkOutput({e.name, "_rem"}, r, e.exp_rem);
  endtask

  initial begin
    int rad;
    int d;
    int r;
    int waited;
    bit seen;
    total = 0;
    bad = 0;

    vecs[0] = '{0, 0, 0};
    vecs[1] = '{255, 15, 30};
    vecs[2] = '{16, 4, 0};
    vecs[3] = '{15, 3, 6};
    vecs[4] = '{200, 14, 4};
    vecs[5] = '{1, 1, 0};
    vecs[6] = '{100, 10, 0};
    vecs[7] = '{2, 1, 1};
    vecs[8] = '{3, 1, 2};
    vecs[9] = '{224, 14, 28};

    // Reset with radicand 0: outputs must be zero during reset.
    rst = 1'b1;
    bus.radicand = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_dout", int'(bus.dout), 0);
    checkOutput("reset_rem", int'(bus.remainder), 0);
`ifdef SQUARE_EXTRACTOR_DONE_EN
    checkOutput("reset_done", int'(bus.done), 0);
`endif
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rad, vecs[i].exp_dout, vecs[i].exp_rem);
      popAndCheck();
    end

    // Reset mid-computation: previous result 255 -> 15/30 is on the outputs.
    applyStimulus("pre_abort", 255, 15, 30);
    popAndCheck();
    @(negedge clk);
    bus.radicand = 8'd100;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_dout", int'(bus.dout), 0);
    checkOutput("abort_rem", int'(bus.remainder), 0);
    @(negedge clk);
    rst = 1'b0;
    waited = 0;
    seen = 1'b0;
    while (waited < 10 && !seen) begin
      @(negedge clk);
      waited++;
      if (bus.dout == 4'd10 && bus.remainder == 8'd0) seen = 1'b1;
    end
    checkOutput("abort_recover", int'(seen), 1);

`ifdef SQUARE_EXTRACTOR_DONE_EN
    // done must pulse once per 5-cycle period.
    begin
      int pulses;
      pulses = 0;
      repeat (50) begin
        @(negedge clk);
        if (bus.done) pulses++;
      end
      checkOutput("done_pulses", pulses, 10);
    end
`endif

    // Random radicands against the model and the result invariants.
    for (int i = 0; i < 1000; i++) begin
      rad = int'($urandom_range(0, 255));
      applyStimulus("rand", rad, isqrt(rad), rad - isqrt(rad) * isqrt(rad));
      d = int'(bus.dout);
      r = int'(bus.remainder);
      checkOutput("rand_identity", d * d + r, rad);
      checkOutput("rand_rem_bound", int'(r <= 2 * d), 1);
      popAndCheck();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
